// File: rtl/ifid_pipe_reg.sv
// ifid_pipe_reg: IF/ID pipeline register between fetch and decode.
//   Two-entry buffer (main + skid) with a valid/ready handshake on both sides,
//   stall support (out_ready low) and a synchronous flush that turns the stage
//   into a bubble. in_ready is a flop, so it never depends combinationally on
//   out_ready.
// Optional feature macro: IFID_PERF_CNT_EN (adds CNT_W, stall_cnt, flush_cnt).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   flush                               discard held and incoming entries
//   in_valid/in_ready                   fetch-side handshake
//   instruction, incremented_pc         fetch-side payload
//   out_valid/out_ready                 decode-side handshake
//   instruction_reg, incremented_pc_reg registered payload (NOP/0 when idle)
//   stall_cnt, flush_cnt                saturating perf counters (macro only)
module ifid_pipe_reg #(
    parameter int unsigned        INSTR_W   = 32,
    parameter int unsigned        PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
`ifdef IFID_PERF_CNT_EN
    ,
    parameter int unsigned        CNT_W     = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [PC_W-1:0]    incremented_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instruction_reg,
    output logic [PC_W-1:0]    incremented_pc_reg
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    // Encoding equals occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_d;
    logic [PC_W-1:0]    pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic               acc, pop;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // Next-state and next-payload decode; flush overrides everything.
    always_comb begin
        state_d      = state_q;
        instr_d      = instruction_reg;
        pc_d         = incremented_pc_reg;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            state_d      = EMPTY;
            instr_d      = NOP_INSTR;
            pc_d         = '0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = FULL;
                        instr_d = instruction;
                        pc_d    = incremented_pc;
                    end
                end
                FULL: begin
                    if (acc && pop) begin
                        instr_d = instruction;
                        pc_d    = incremented_pc;
                    end else if (acc) begin
                        state_d      = SKID;
                        skid_instr_d = instruction;
                        skid_pc_d    = incremented_pc;
                    end else if (pop) begin
                        state_d = EMPTY;
                        instr_d = NOP_INSTR;
                        pc_d    = '0;
                    end
                end
                SKID: begin
                    // Skid keeps its stale copy until overwritten; it is never
                    // observable once the state leaves SKID.
                    if (pop) begin
                        state_d = FULL;
                        instr_d = skid_instr_q;
                        pc_d    = skid_pc_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    instr_d = NOP_INSTR;
                    pc_d    = '0;
                end
            endcase
        end
    end

    // State, payload and handshake flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= EMPTY;
            out_valid          <= 1'b0;
            in_ready           <= 1'b1;
            instruction_reg    <= NOP_INSTR;
            incremented_pc_reg <= '0;
            skid_instr_q       <= '0;
            skid_pc_q          <= '0;
        end else begin
            state_q            <= state_d;
            out_valid          <= (state_d != EMPTY);
            in_ready           <= (state_d != SKID);
            instruction_reg    <= instr_d;
            incremented_pc_reg <= pc_d;
            skid_instr_q       <= skid_instr_d;
            skid_pc_q          <= skid_pc_d;
        end
    end

`ifdef IFID_PERF_CNT_EN
    // Saturating stall / flush event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// tb_ifid_pipe_reg: self-checking bench for ifid_pipe_reg.
//   Reference model is a FIFO queue of at most two entries: out_valid means
//   non-empty, the head is the output, in_ready means fewer than two entries.
module tb_ifid_pipe_reg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
`ifdef IFID_PERF_CNT_EN
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;
`else
    localparam int          CNT_MAX = 65535;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] instruction = '0;
    logic [PC_W-1:0]    incremented_pc = '0;
    logic [INSTR_W-1:0] instruction_reg;
    logic [PC_W-1:0]    incremented_pc_reg;
`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;
`endif

    always #5 clk = ~clk;

`ifdef IFID_PERF_CNT_EN
    ifid_pipe_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR('0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .incremented_pc(incremented_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .instruction_reg(instruction_reg), .incremented_pc_reg(incremented_pc_reg),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
`else
    ifid_pipe_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR('0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .incremented_pc(incremented_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .instruction_reg(instruction_reg), .incremented_pc_reg(incremented_pc_reg)
    );
`endif

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    entry_t q[$];
    int     stall_m = 0;
    int     flush_m = 0;
    int     checks  = 0;
    int     errors  = 0;

    function automatic logic exp_valid();
        return q.size() != 0;
    endfunction

    function automatic logic exp_ready();
        return q.size() < 2;
    endfunction

    function automatic logic [INSTR_W-1:0] exp_instr();
        return (q.size() != 0) ? q[0].instr : '0;
    endfunction

    function automatic logic [PC_W-1:0] exp_pc();
        return (q.size() != 0) ? q[0].pc : '0;
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge,
    // return at the following negedge with outputs settled.
    task automatic drive_cycle(input logic fl, input logic iv,
                               input logic [INSTR_W-1:0] ins,
                               input logic [PC_W-1:0] pc, input logic ordy);
        bit acc, pop;
        flush = fl; in_valid = iv; instruction = ins; incremented_pc = pc; out_ready = ordy;
        acc = iv && (q.size() < 2);
        pop = ordy && (q.size() != 0);
        if (q.size() != 0 && !ordy && stall_m < CNT_MAX) stall_m++;
        if (fl && flush_m < CNT_MAX) flush_m++;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{instr: ins, pc: pc});
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        q.delete(); stall_m = 0; flush_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Fill to two entries, then assert reset between edges.
        rst_n = 1'b1;
        @(negedge clk);
        drive_cycle(0, 1, 32'h1111_0001, 32'h4, 0);
        drive_cycle(0, 1, 32'h2222_0002, 32'h8, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (instruction_reg !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instruction_reg); end
        checks++; if (incremented_pc_reg !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", incremented_pc_reg); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
`ifdef IFID_PERF_CNT_EN
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
`endif
        q.delete(); stall_m = 0; flush_m = 0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(0, 0, '0, '0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_partial got %0b exp 0", out_valid); end
    endtask

    task automatic test_stream();
        drive_cycle(0, 1, 32'h2002_0005, 32'd4, 1);
        checks++; if (out_valid !== 1'b1 || instruction_reg !== 32'h2002_0005 || incremented_pc_reg !== 32'd4) begin
            errors++; $display("FAIL stream_first got v=%0b %h/%h exp 1 20020005/4", out_valid, instruction_reg, incremented_pc_reg); end
        drive_cycle(0, 1, 32'h2003_0007, 32'd8, 1);
        checks++; if (out_valid !== 1'b1 || instruction_reg !== 32'h2003_0007 || incremented_pc_reg !== 32'd8) begin
            errors++; $display("FAIL stream_second got v=%0b %h/%h exp 1 20030007/8", out_valid, instruction_reg, incremented_pc_reg); end
        drive_cycle(0, 0, '0, '0, 1);
        checks++; if (out_valid !== 1'b0 || instruction_reg !== 32'h0) begin
            errors++; $display("FAIL stream_drain got v=%0b %h exp 0 0", out_valid, instruction_reg); end
    endtask

    task automatic test_stall();
        drive_cycle(0, 1, 32'hAAAA_0001, 32'h10, 0);
        checks++; if (in_ready !== 1'b1 || instruction_reg !== 32'hAAAA_0001) begin
            errors++; $display("FAIL stall_full got rdy=%0b %h exp 1 aaaa0001", in_ready, instruction_reg); end
        drive_cycle(0, 1, 32'hBBBB_0002, 32'h14, 0);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || instruction_reg !== 32'hAAAA_0001 || incremented_pc_reg !== 32'h10) begin
            errors++; $display("FAIL stall_skid got rdy=%0b v=%0b %h/%h exp 0 1 aaaa0001/10", in_ready, out_valid, instruction_reg, incremented_pc_reg); end
        drive_cycle(0, 1, 32'hDEAD_0009, 32'h18, 0);
        checks++; if (in_ready !== 1'b0 || instruction_reg !== 32'hAAAA_0001 || incremented_pc_reg !== 32'h10) begin
            errors++; $display("FAIL stall_hold got rdy=%0b %h/%h exp 0 aaaa0001/10", in_ready, instruction_reg, incremented_pc_reg); end
        drive_cycle(0, 0, '0, '0, 1);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || instruction_reg !== 32'hBBBB_0002 || incremented_pc_reg !== 32'h14) begin
            errors++; $display("FAIL stall_release got v=%0b rdy=%0b %h/%h exp 1 1 bbbb0002/14", out_valid, in_ready, instruction_reg, incremented_pc_reg); end
        drive_cycle(0, 0, '0, '0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %0b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        drive_cycle(0, 1, 32'h0101_0001, 32'h20, 0);
        drive_cycle(0, 1, 32'h0202_0002, 32'h24, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_skid got %0b exp 0", in_ready); end
        drive_cycle(1, 1, 32'hCCCC_0003, 32'h28, 0);
        checks++; if (out_valid !== 1'b0 || instruction_reg !== 32'h0 || incremented_pc_reg !== 32'h0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_bubble got v=%0b %h/%h rdy=%0b exp 0 0/0 1", out_valid, instruction_reg, incremented_pc_reg, in_ready); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, '0, '0, 1);
            checks++; if (out_valid !== 1'b0 || instruction_reg === 32'hCCCC_0003) begin
                errors++; $display("FAIL flush_no_emit cyc %0d got v=%0b %h exp 0 0", i, out_valid, instruction_reg); end
        end
    endtask

    task automatic test_drain();
        drive_cycle(0, 1, 32'h3333_0003, 32'h30, 0);
        drive_cycle(0, 0, '0, '0, 1);
        checks++; if (out_valid !== 1'b0 || instruction_reg !== 32'h0 || incremented_pc_reg !== 32'h0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL drain got v=%0b %h/%h rdy=%0b exp 0 0/0 1", out_valid, instruction_reg, incremented_pc_reg, in_ready); end
    endtask

    task automatic test_random();
        logic fl, iv, ordy;
        for (int c = 0; c < 600; c++) begin
            fl   = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 9) < 6);
            drive_cycle(fl, iv, INSTR_W'($urandom), PC_W'($urandom), ordy);
            checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid cyc %0d got %0b exp %0b", c, out_valid, exp_valid()); end
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready cyc %0d got %0b exp %0b", c, in_ready, exp_ready()); end
            checks++; if (instruction_reg !== exp_instr()) begin errors++; $display("FAIL rand_instr cyc %0d got %h exp %h", c, instruction_reg, exp_instr()); end
            checks++; if (incremented_pc_reg !== exp_pc()) begin errors++; $display("FAIL rand_pc cyc %0d got %h exp %h", c, incremented_pc_reg, exp_pc()); end
`ifdef IFID_PERF_CNT_EN
            checks++; if (int'(stall_cnt) != stall_m) begin errors++; $display("FAIL rand_stall_cnt cyc %0d got %0d exp %0d", c, stall_cnt, stall_m); end
            checks++; if (int'(flush_cnt) != flush_m) begin errors++; $display("FAIL rand_flush_cnt cyc %0d got %0d exp %0d", c, flush_cnt, flush_m); end
`endif
        end
    endtask

`ifdef IFID_PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        drive_cycle(0, 1, 32'h4444_0004, 32'h40, 0);
        for (int i = 0; i < 20; i++) drive_cycle(0, 0, '0, '0, 0);
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL perf_stall_sat got %0d exp 15", stall_cnt); end
        drive_cycle(1, 0, '0, '0, 0);
        drive_cycle(1, 0, '0, '0, 0);
        checks++; if (flush_cnt !== 4'd2) begin errors++; $display("FAIL perf_flush got %0d exp 2", flush_cnt); end
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL perf_stall_hold got %0d exp 15", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_drain();
        test_random();
`ifdef IFID_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
